mc_controller_v2: RTL and testbench

Multicycle MIPS control unit with a memory-ready handshake, a bounded wait timer and a fully enumerated state machine. It replaces the fixed-timing controller, drives every datapath select and enable in the multicycle core, and computes the final PC enable internally from `zero`. It adds `bne`, `jal` and `jr`, plus illegal-opcode and memory-timeout reporting.

---
 rtl/mc_controller_v2_pkg.sv | 58 +++++
 rtl/mc_controller_v2_if.sv | 41 ++++
 rtl/mc_controller_v2_wait_timer.sv | 34 +++
 rtl/mc_controller_v2.sv | 203 ++++++++++++++++++++
 tb/tb_mc_controller_v2.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_controller_v2_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit:
// state enum, opcode/funct constants and datapath select encodings.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_INIT,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC_R,
        ST_EXEC_I,
        ST_MEM_ADDR,
        ST_MEM_RD,
        ST_MEM_WB,
        ST_MEM_WR,
        ST_R_WB,
        ST_I_WB,
        ST_BRANCH,
        ST_JUMP,
        ST_JAL,
        ST_JR,
        ST_FAULT
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_AND   = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_REGA   = 2'b11;

    localparam logic [1:0] DST_RT = 2'b00;
    localparam logic [1:0] DST_RD = 2'b01;
    localparam logic [1:0] DST_RA = 2'b10;

    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MDR    = 2'b01;
    localparam logic [1:0] WB_PC     = 2'b10;

endpackage

// File: rtl/mc_controller_v2_if.sv
// Control bus between the multicycle controller (master) and the datapath (slave).
interface mc_controller_v2_if #(
    parameter int OP_W = 6
);
    logic [OP_W-1:0] opcode;
    logic [OP_W-1:0] opr;
    logic            zero;
    logic            mem_ready;

    logic       selreg;
    logic       alusrcA;
    logic       memread;
    logic       memwrite;
    logic       regwrite;
    logic       IorD;
    logic       IR_write;
    logic       pc_write;
    logic       pc_write_condition;
    logic [1:0] alusrcB;
    logic [1:0] toaluctrl;
    logic [1:0] pc_src;
    logic [1:0] regdst;
    logic [1:0] memtoreg;
    logic       pc_en;
    logic       illegal_op;
    logic       fault;

    modport master (
        input  opcode, opr, zero, mem_ready,
        output selreg, alusrcA, memread, memwrite, regwrite, IorD, IR_write,
               pc_write, pc_write_condition, alusrcB, toaluctrl, pc_src,
               regdst, memtoreg, pc_en, illegal_op, fault
    );

    modport slave (
        output opcode, opr, zero, mem_ready,
        input  selreg, alusrcA, memread, memwrite, regwrite, IorD, IR_write,
               pc_write, pc_write_condition, alusrcB, toaluctrl, pc_src,
               regdst, memtoreg, pc_en, illegal_op, fault
    );
endinterface

// File: rtl/mc_controller_v2_wait_timer.sv
// Counts consecutive memory wait cycles; expired flags the wait cycle in which
// the count reaches WAIT_LIMIT (never when WAIT_LIMIT is 0).
module mc_wait_timer #(
    parameter int WAIT_LIMIT = 15,
    parameter int CNT_W      = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic count_en,
    input  logic clr,
    output logic expired
);

    localparam bit             TIMEOUT_ON = (WAIT_LIMIT > 32'sd0);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WAIT_LIMIT - 32'sd1);

    logic [CNT_W-1:0] cnt_r;

    // wait-cycle counter, cleared whenever the memory is not being waited on
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (count_en) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expired = TIMEOUT_ON && count_en && !clr && (cnt_r == LAST_CNT);

endmodule

// File: rtl/mc_controller_v2.sv
// Multicycle MIPS control unit: memory-ready handshake, bounded wait timeout,
// illegal-opcode pulse and internal PC-enable generation.
module mc_controller_v2 #(
    parameter int OP_W       = 6,
    parameter int WAIT_LIMIT = 15,
    parameter int CNT_W      = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    mc_controller_v2_if.master bus
);
    import mc_ctrl_pkg::*;

    state_t          state_r;
    state_t          next_state_s;
    logic [OP_W-1:0] op_s;
    logic [OP_W-1:0] fn_s;
    logic            wait_state_s;
    logic            count_en_s;
    logic            clr_s;
    logic            expired_s;
    logic            is_bne_s;

    assign op_s         = bus.opcode;
    assign fn_s         = bus.opr;
    assign wait_state_s = (state_r == ST_FETCH) || (state_r == ST_MEM_RD) || (state_r == ST_MEM_WR);
    assign count_en_s   = wait_state_s && !bus.mem_ready;
    assign clr_s        = !count_en_s;
    assign is_bne_s     = (op_s == OP_BNE);

    mc_wait_timer #(
        .WAIT_LIMIT (WAIT_LIMIT),
        .CNT_W      (CNT_W)
    ) u_wait_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .count_en (count_en_s),
        .clr      (clr_s),
        .expired  (expired_s)
    );

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_INIT;
        end else begin
            state_r <= next_state_s;
        end
    end

    // next-state and control decode
    always_comb begin
        next_state_s           = state_r;
        bus.selreg             = 1'b0;
        bus.alusrcA            = 1'b0;
        bus.memread            = 1'b0;
        bus.memwrite           = 1'b0;
        bus.regwrite           = 1'b0;
        bus.IorD               = 1'b0;
        bus.IR_write           = 1'b0;
        bus.pc_write           = 1'b0;
        bus.pc_write_condition = 1'b0;
        bus.alusrcB            = SRCB_REG;
        bus.toaluctrl          = ALU_ADD;
        bus.pc_src             = PC_ALU;
        bus.regdst             = DST_RT;
        bus.memtoreg           = WB_ALUOUT;
        bus.illegal_op         = 1'b0;
        bus.fault              = 1'b0;

        case (state_r)
            ST_INIT: next_state_s = ST_FETCH;
            ST_FETCH: begin
                bus.memread  = 1'b1;
                bus.alusrcB  = SRCB_FOUR;
                bus.IR_write = bus.mem_ready;
                bus.pc_write = bus.mem_ready;
                if (bus.mem_ready) begin
                    next_state_s = ST_DECODE;
                end else if (expired_s) begin
                    next_state_s = ST_FAULT;
                end else begin
                    next_state_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                bus.alusrcB = SRCB_IMM_SH2;
                case (op_s)
                    OP_RTYPE: begin
                        if (fn_s == FN_JR) begin
                            next_state_s = ST_JR;
                        end else begin
                            next_state_s = ST_EXEC_R;
                        end
                    end
                    OP_ADDI, OP_ANDI: next_state_s = ST_EXEC_I;
                    OP_LW, OP_SW:     next_state_s = ST_MEM_ADDR;
                    OP_BEQ, OP_BNE:   next_state_s = ST_BRANCH;
                    OP_J:             next_state_s = ST_JUMP;
                    OP_JAL:           next_state_s = ST_JAL;
                    default: begin
                        bus.illegal_op = 1'b1;
                        next_state_s   = ST_FETCH;
                    end
                endcase
            end
            ST_EXEC_R: begin
                bus.alusrcA   = 1'b1;
                bus.toaluctrl = ALU_FUNCT;
                next_state_s  = ST_R_WB;
            end
            ST_R_WB: begin
                bus.regdst   = DST_RD;
                bus.regwrite = 1'b1;
                next_state_s = ST_FETCH;
            end
            ST_EXEC_I: begin
                bus.alusrcA = 1'b1;
                bus.alusrcB = SRCB_IMM;
                if (op_s == OP_ANDI) begin
                    bus.toaluctrl = ALU_AND;
                end else begin
                    bus.toaluctrl = ALU_ADD;
                end
                next_state_s = ST_I_WB;
            end
            ST_I_WB: begin
                bus.regwrite = 1'b1;
                next_state_s = ST_FETCH;
            end
            ST_MEM_ADDR: begin
                bus.alusrcA = 1'b1;
                bus.alusrcB = SRCB_IMM;
                if (op_s == OP_LW) begin
                    next_state_s = ST_MEM_RD;
                end else begin
                    next_state_s = ST_MEM_WR;
                end
            end
            ST_MEM_RD: begin
                bus.memread = 1'b1;
                bus.IorD    = 1'b1;
                if (bus.mem_ready) begin
                    next_state_s = ST_MEM_WB;
                end else if (expired_s) begin
                    next_state_s = ST_FAULT;
                end else begin
                    next_state_s = ST_MEM_RD;
                end
            end
            ST_MEM_WB: begin
                bus.memtoreg = WB_MDR;
                bus.regwrite = 1'b1;
                next_state_s = ST_FETCH;
            end
            ST_MEM_WR: begin
                bus.memwrite = 1'b1;
                bus.IorD     = 1'b1;
                if (bus.mem_ready) begin
                    next_state_s = ST_FETCH;
                end else if (expired_s) begin
                    next_state_s = ST_FAULT;
                end else begin
                    next_state_s = ST_MEM_WR;
                end
            end
            ST_BRANCH: begin
                bus.alusrcA            = 1'b1;
                bus.toaluctrl          = ALU_SUB;
                bus.pc_src             = PC_ALUOUT;
                bus.pc_write_condition = 1'b1;
                next_state_s           = ST_FETCH;
            end
            ST_JUMP: begin
                bus.pc_src   = PC_JUMP;
                bus.pc_write = 1'b1;
                next_state_s = ST_FETCH;
            end
            ST_JAL: begin
                bus.pc_src   = PC_JUMP;
                bus.pc_write = 1'b1;
                bus.regdst   = DST_RA;
                bus.memtoreg = WB_PC;
                bus.regwrite = 1'b1;
                next_state_s = ST_FETCH;
            end
            ST_JR: begin
                bus.pc_src   = PC_REGA;
                bus.pc_write = 1'b1;
                next_state_s = ST_FETCH;
            end
            ST_FAULT: begin
                bus.fault    = 1'b1;
                next_state_s = ST_FAULT;
            end
            default: next_state_s = ST_INIT;
        endcase
    end

    // bne inverts the sense of the ALU zero flag for the conditional PC load
    assign bus.pc_en = bus.pc_write | (bus.pc_write_condition & (bus.zero ^ is_bne_s));

endmodule

// File: tb/tb_mc_controller_v2.sv
// Randomized instruction-stream bench: a per-instruction cycle-sequence model
// predicts every control output, compared against the DUT each cycle.
module tb_mc_controller_v2;

    typedef struct packed {
        logic       selreg;
        logic       alusrcA;
        logic       memread;
        logic       memwrite;
        logic       regwrite;
        logic       IorD;
        logic       IR_write;
        logic       pc_write;
        logic       pc_write_condition;
        logic [1:0] alusrcB;
        logic [1:0] toaluctrl;
        logic [1:0] pc_src;
        logic [1:0] regdst;
        logic [1:0] memtoreg;
        logic       pc_en;
        logic       illegal_op;
        logic       fault;
    } ctl_t;

    localparam logic [5:0] O_R = 6'b000000, O_ADDI = 6'b001000, O_ANDI = 6'b001100,
                           O_LW = 6'b100011, O_SW = 6'b101011, O_BEQ = 6'b000100,
                           O_BNE = 6'b000101, O_J = 6'b000010, O_JAL = 6'b000011;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   base;

    ctl_t       exp_q[$];
    bit         mr_q[$];
    bit         z_q[$];
    logic [5:0] op_q[$];
    logic [5:0] fn_q[$];

    logic [5:0] kop [14] = '{6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b001000, 6'b001100,
                             6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b000010, 6'b000011,
                             6'b111111, 6'b010000};
    logic [5:0] kfn [4]  = '{6'b100000, 6'b100010, 6'b100100, 6'b001000};

    mc_controller_v2_if #(.OP_W(6)) bus ();

    mc_controller_v2 #(
        .OP_W       (6),
        .WAIT_LIMIT (4),
        .CNT_W      (3)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    function automatic ctl_t cur_ctl();
        ctl_t c;
        c.selreg             = bus.selreg;
        c.alusrcA            = bus.alusrcA;
        c.memread            = bus.memread;
        c.memwrite           = bus.memwrite;
        c.regwrite           = bus.regwrite;
        c.IorD               = bus.IorD;
        c.IR_write           = bus.IR_write;
        c.pc_write           = bus.pc_write;
        c.pc_write_condition = bus.pc_write_condition;
        c.alusrcB            = bus.alusrcB;
        c.toaluctrl          = bus.toaluctrl;
        c.pc_src             = bus.pc_src;
        c.regdst             = bus.regdst;
        c.memtoreg           = bus.memtoreg;
        c.pc_en              = bus.pc_en;
        c.illegal_op         = bus.illegal_op;
        c.fault              = bus.fault;
        return c;
    endfunction

    task automatic compare(input string name, input ctl_t exp);
        ctl_t act;
        act = cur_ctl();
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic pin(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL pin_%s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic bit legal(input logic [5:0] op);
        return op inside {O_R, O_ADDI, O_ANDI, O_LW, O_SW, O_BEQ, O_BNE, O_J, O_JAL};
    endfunction

    task automatic push(input ctl_t c, input bit mr, input logic [5:0] op, input logic [5:0] fn, input bit z);
        exp_q.push_back(c);
        mr_q.push_back(mr);
        op_q.push_back(op);
        fn_q.push_back(fn);
        z_q.push_back(z);
    endtask

    // Expected per-cycle control sequence for one whole instruction.
    task automatic gen_instr(input logic [5:0] op, input logic [5:0] fn, input int wf, input int wm, input bit z);
        ctl_t c;
        for (int i = 0; i < wf; i++) begin
            c = '0; c.memread = 1'b1; c.alusrcB = 2'b01;
            push(c, 1'b0, op, fn, rb());
        end
        c = '0; c.memread = 1'b1; c.alusrcB = 2'b01; c.IR_write = 1'b1; c.pc_write = 1'b1; c.pc_en = 1'b1;
        push(c, 1'b1, op, fn, rb());
        c = '0; c.alusrcB = 2'b11; c.illegal_op = !legal(op);
        push(c, rb(), op, fn, rb());
        case (op)
            O_R: begin
                if (fn == 6'b001000) begin
                    c = '0; c.pc_src = 2'b11; c.pc_write = 1'b1; c.pc_en = 1'b1;
                    push(c, rb(), op, fn, rb());
                end else begin
                    c = '0; c.alusrcA = 1'b1; c.toaluctrl = 2'b10;
                    push(c, rb(), op, fn, rb());
                    c = '0; c.regdst = 2'b01; c.regwrite = 1'b1;
                    push(c, rb(), op, fn, rb());
                end
            end
            O_ADDI, O_ANDI: begin
                c = '0; c.alusrcA = 1'b1; c.alusrcB = 2'b10; c.toaluctrl = (op == O_ANDI) ? 2'b11 : 2'b00;
                push(c, rb(), op, fn, rb());
                c = '0; c.regwrite = 1'b1;
                push(c, rb(), op, fn, rb());
            end
            O_LW, O_SW: begin
                c = '0; c.alusrcA = 1'b1; c.alusrcB = 2'b10;
                push(c, rb(), op, fn, rb());
                c = '0; c.IorD = 1'b1; c.memread = (op == O_LW); c.memwrite = (op == O_SW);
                for (int i = 0; i < wm; i++) push(c, 1'b0, op, fn, rb());
                push(c, 1'b1, op, fn, rb());
                if (op == O_LW) begin
                    c = '0; c.memtoreg = 2'b01; c.regwrite = 1'b1;
                    push(c, rb(), op, fn, rb());
                end
            end
            O_BEQ, O_BNE: begin
                c = '0; c.alusrcA = 1'b1; c.toaluctrl = 2'b01; c.pc_src = 2'b01; c.pc_write_condition = 1'b1;
                c.pc_en = (op == O_BNE) ? !z : z;
                push(c, rb(), op, fn, z);
            end
            O_J, O_JAL: begin
                c = '0; c.pc_src = 2'b10; c.pc_write = 1'b1; c.pc_en = 1'b1;
                if (op == O_JAL) begin
                    c.regdst = 2'b10; c.memtoreg = 2'b10; c.regwrite = 1'b1;
                end
                push(c, rb(), op, fn, rb());
            end
            default: ;
        endcase
    endtask

    task automatic gen_random(input int n);
        int k;
        logic [5:0] fn;
        for (int i = 0; i < n; i++) begin
            k  = $urandom_range(0, 13);
            fn = (k < 4) ? kfn[k] : 6'($urandom_range(0, 63));
            gen_instr(kop[k], fn, $urandom_range(0, 3), $urandom_range(0, 3), rb());
        end
    endtask

    task automatic run_queue();
        while (exp_q.size() > 0) begin
            @(posedge clk);
            #1;
            bus.mem_ready = mr_q.pop_front();
            bus.zero      = z_q.pop_front();
            bus.opcode    = op_q.pop_front();
            bus.opr       = fn_q.pop_front();
            cyc++;
            @(negedge clk);
            compare("stream", exp_q.pop_front());
        end
    endtask

    initial begin
        ctl_t c;
        bus.opcode = 6'b0; bus.opr = 6'b0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
        @(negedge clk);
        compare("reset_state", '0);
        @(posedge clk);
        #2 reset_n = 1'b1;
        #1 compare("init_state", '0);

        base = exp_q.size();
        gen_instr(O_R, 6'b100000, 0, 0, 1'b0);
        pin("add_cycles", exp_q.size() - base, 4);
        pin("add_wb", int'({exp_q[base+3].regwrite, exp_q[base+3].regdst}), 5);
        base = exp_q.size();
        gen_instr(O_LW, 6'b0, 0, 3, 1'b0);
        pin("lw_cycles", exp_q.size() - base, 8);
        pin("lw_wb", int'({exp_q[base+7].regwrite, exp_q[base+7].memtoreg}), 5);
        base = exp_q.size();
        gen_instr(O_BNE, 6'b0, 0, 0, 1'b0);
        gen_instr(O_BNE, 6'b0, 0, 0, 1'b1);
        gen_instr(O_BEQ, 6'b0, 0, 0, 1'b0);
        gen_instr(O_BEQ, 6'b0, 0, 0, 1'b1);
        pin("branch_pc_en", int'({exp_q[base+2].pc_en, exp_q[base+5].pc_en, exp_q[base+8].pc_en, exp_q[base+11].pc_en}), 9);
        base = exp_q.size();
        gen_instr(O_JAL, 6'b0, 0, 0, 1'b0);
        pin("jal_c3", int'({exp_q[base+2].regdst, exp_q[base+2].memtoreg, exp_q[base+2].regwrite, exp_q[base+2].pc_src}), 7'b1010110);
        base = exp_q.size();
        gen_instr(O_R, 6'b001000, 0, 0, 1'b0);
        pin("jr_c3", int'(exp_q[base+2].pc_src), 3);
        base = exp_q.size();
        gen_instr(6'b111111, 6'b0, 0, 0, 1'b0);
        pin("illegal", int'({exp_q[base+1].illegal_op, 1'(exp_q.size() - base)}), 2'b10);
        gen_instr(O_SW, 6'b0, 3, 3, 1'b0);
        gen_instr(O_LW, 6'b0, 3, 3, 1'b0);
        gen_random(60);
        for (int i = 0; i < 4; i++) begin
            c = '0; c.memread = 1'b1; c.alusrcB = 2'b01;
            push(c, 1'b0, O_R, 6'b0, rb());
        end
        for (int i = 0; i < 5; i++) begin
            c = '0; c.fault = 1'b1;
            push(c, rb(), 6'($urandom_range(0, 63)), 6'b0, rb());
        end
        run_queue();

        @(posedge clk);
        #1 cyc++;
        c = '0; c.fault = 1'b1;
        compare("fault_sticky", c);
        #2 reset_n = 1'b0;
        #1 compare("reset_clears_fault", '0);
        @(negedge clk);
        compare("reset_held", '0);
        @(posedge clk);
        #2 reset_n = 1'b1;
        #1 compare("init_after_fault", '0);

        gen_random(30);
        for (int i = 0; i < 2; i++) begin
            c = '0; c.memread = 1'b1; c.alusrcB = 2'b01;
            push(c, 1'b0, O_R, 6'b0, rb());
        end
        run_queue();
        @(posedge clk);
        #1 cyc++;
        c = '0; c.memread = 1'b1; c.alusrcB = 2'b01;
        compare("mid_wait", c);
        #2 reset_n = 1'b0;
        #1 compare("reset_mid_wait", '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
